// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the dmem_ctrl data-memory controller.
//   - memory operation encoding (OP_*)
//   - controller FSM state encoding
//   - byte-lane enable, load-extend and byte parity helpers
// Byte 0 is the most significant byte (bits [31:24]); lane bit 3 maps to byte 0.
package dmem_pkg;

    localparam logic [2:0] OP_W   = 3'b000;
    localparam logic [2:0] OP_SH  = 3'b001;
    localparam logic [2:0] OP_SB  = 3'b010;
    localparam logic [2:0] OP_LH  = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;
    localparam logic [2:0] OP_LB  = 3'b110;
    localparam logic [2:0] OP_LBU = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Lanes touched by an access; load opcodes share the store lane map so
    // the same helper selects lanes for parity checking.
    function automatic logic [3:0] lane_en(input logic [2:0] op, input logic [1:0] a);
        logic [3:0] l;
        l = 4'b0000;
        case (op)
            OP_W:                 l = 4'b1111;
            OP_SH, OP_LH, OP_LHU: l = a[1] ? 4'b0011 : 4'b1100;
            OP_SB, OP_LB, OP_LBU: l = 4'b1000 >> a;
            default:              l = 4'b0000;
        endcase
        return l;
    endfunction

    // Select the addressed byte/half of a RAM word and extend it.
    function automatic logic [31:0] load_ext(input logic [2:0] op, input logic [1:0] a,
                                             input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'b00:   b = word[31:24];
            2'b01:   b = word[23:16];
            2'b10:   b = word[15:8];
            default: b = word[7:0];
        endcase
        h = a[1] ? word[15:0] : word[31:16];
        case (op)
            OP_W:    r = word;
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LHU:  r = {16'h0000, h};
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'h000000, b};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Even parity bit: makes the 9-bit {parity, byte} group have an even count of ones.
    function automatic logic even_par(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: byte-write-enabled synchronous RAM, four lanes per word.
//   clk_i    clock
//   we_i     per-lane write enable (bit 3 = lane at the top of the word)
//   re_i     read enable; read word appears RD_LAT cycles later
//   addr_i   word index
//   wdata_i  write word, LANE_W bits per lane
//   rdata_o  read word
// RD_LAT=2 adds an output register behind the array read register.
// Contents are never reset.
module dmem_ram #(
    parameter int DEPTH_LOG2 = 14,
    parameter int RD_LAT     = 1,
    parameter int LANE_W     = 8
) (
    input  logic                  clk_i,
    input  logic [3:0]            we_i,
    input  logic                  re_i,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic [4*LANE_W-1:0]   wdata_i,
    output logic [4*LANE_W-1:0]   rdata_o
);

    logic [4*LANE_W-1:0] mem_q [0:(1<<DEPTH_LOG2)-1];
    logic [4*LANE_W-1:0] rd1_q;

    // Lane-masked write and registered read of the array.
    always_ff @(posedge clk_i) begin
        for (int l = 0; l < 4; l++) begin
            if (we_i[l]) begin
                mem_q[addr_i][l*LANE_W +: LANE_W] <= wdata_i[l*LANE_W +: LANE_W];
            end
        end
        if (re_i) begin
            rd1_q <= mem_q[addr_i];
        end
    end

    generate
        if (RD_LAT == 2) begin : g_oreg
            logic [4*LANE_W-1:0] rd2_q;
            // Extra output stage for the two-cycle read option.
            always_ff @(posedge clk_i) begin
                rd2_q <= rd1_q;
            end
            assign rdata_o = rd2_q;
        end else begin : g_noreg
            assign rdata_o = rd1_q;
        end
    endgenerate

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: handshaked load/store front end owning the data RAM.
//   clk, rst          clock, synchronous active-high reset
//   req_*             request channel (valid/ready, we, byte address, data, op)
//   resp_*            response channel (valid/ready, extended data, fault flags)
//   busy_o            controller not idle
// Optional build macro DMEM_CTRL_PARITY_EN: stores one even-parity bit per
// byte and adds resp_perr_o, flagged on loads whose addressed lanes fail parity.
// Address bits above DEPTH_LOG2+1 are ignored (aliasing, no fault).
import dmem_pkg::*;

module dmem_ctrl #(
    parameter int DEPTH_LOG2 = 14,
    parameter int RD_LAT     = 1,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    input  logic [2:0]        req_op_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [31:0]       resp_rdata_o,
    output logic              resp_adel_o,
    output logic              resp_ades_o,
    output logic              busy_o
`ifdef DMEM_CTRL_PARITY_EN
    ,
    output logic              resp_perr_o
`endif
);

`ifdef DMEM_CTRL_PARITY_EN
    localparam int LANE_W = 9;
`else
    localparam int LANE_W = 8;
`endif
    localparam logic [1:0] RD_LAT_C = RD_LAT[1:0];

    state_e                state_q;
    logic                  req_ready_q;
    logic                  resp_valid_q;
    logic [31:0]           resp_rdata_q;
    logic                  adel_q;
    logic                  ades_q;
    logic                  busy_q;
    logic                  we_q;
    logic [2:0]            op_q;
    logic [DEPTH_LOG2+1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            lanes_q;
    logic [1:0]            cnt_q;
`ifdef DMEM_CTRL_PARITY_EN
    logic                  perr_q;
    logic                  perr_d;
`endif

    logic                  illegal_d;
    logic                  misal_d;
    logic [31:0]           wrep_d;
    logic [3:0]            ram_we_d;
    logic                  ram_re_d;
    logic [4*LANE_W-1:0]   ram_wdata_d;
    logic [4*LANE_W-1:0]   ram_rdata_d;
    logic [31:0]           ram_word_d;
    logic                  addr_unused_d;

    assign addr_unused_d = ^req_addr_i[ADDR_W-1:DEPTH_LOG2+2];

    // Classify the incoming request and replicate store data across lanes.
    always_comb begin
        illegal_d = 1'b0;
        misal_d   = 1'b0;
        wrep_d    = req_wdata_i;
        case (req_op_i)
            OP_W: begin
                misal_d = |req_addr_i[1:0];
            end
            OP_SH: begin
                illegal_d = ~req_we_i;
                misal_d   = req_addr_i[0];
                wrep_d    = {2{req_wdata_i[15:0]}};
            end
            OP_SB: begin
                illegal_d = ~req_we_i;
                wrep_d    = {4{req_wdata_i[7:0]}};
            end
            OP_LH, OP_LHU: begin
                illegal_d = req_we_i;
                misal_d   = req_addr_i[0];
            end
            OP_LB, OP_LBU: begin
                illegal_d = req_we_i;
            end
            default: begin
                illegal_d = 1'b1;
            end
        endcase
    end

    // RAM strobes; rst suppresses a write still pending in ACCESS.
    always_comb begin
        ram_we_d = 4'b0000;
        ram_re_d = 1'b0;
        if ((state_q == ACCESS) && !rst) begin
            ram_we_d = we_q ? lanes_q : 4'b0000;
            ram_re_d = !we_q && (cnt_q == 2'd0);
        end else begin
            ram_we_d = 4'b0000;
            ram_re_d = 1'b0;
        end
    end

    // Pack write lanes (with parity when enabled) and unpack the read word.
    always_comb begin
        ram_wdata_d = '0;
        ram_word_d  = 32'h0000_0000;
`ifdef DMEM_CTRL_PARITY_EN
        perr_d      = 1'b0;
`endif
        for (int l = 0; l < 4; l++) begin
            ram_wdata_d[l*LANE_W +: 8] = wdata_q[l*8 +: 8];
            ram_word_d[l*8 +: 8]       = ram_rdata_d[l*LANE_W +: 8];
`ifdef DMEM_CTRL_PARITY_EN
            ram_wdata_d[l*LANE_W + 8]  = even_par(wdata_q[l*8 +: 8]);
            perr_d = perr_d | (lanes_q[l] & (^ram_rdata_d[l*LANE_W +: LANE_W]));
`endif
        end
    end

    dmem_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .RD_LAT     (RD_LAT),
        .LANE_W     (LANE_W)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we_d),
        .re_i    (ram_re_d),
        .addr_i  (addr_q[DEPTH_LOG2+1:2]),
        .wdata_i (ram_wdata_d),
        .rdata_o (ram_rdata_d)
    );

    // Controller FSM with registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
            adel_q       <= 1'b0;
            ades_q       <= 1'b0;
            busy_q       <= 1'b0;
            cnt_q        <= 2'd0;
`ifdef DMEM_CTRL_PARITY_EN
            perr_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        we_q        <= req_we_i;
                        op_q        <= req_op_i;
                        addr_q      <= req_addr_i[DEPTH_LOG2+1:0];
                        wdata_q     <= wrep_d;
                        lanes_q     <= lane_en(req_op_i, req_addr_i[1:0]);
                        cnt_q       <= 2'd0;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (illegal_d || misal_d) begin
                            // Faulted or illegal: answer directly, RAM untouched.
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= 32'h0000_0000;
                            adel_q       <= misal_d & ~illegal_d & ~req_we_i;
                            ades_q       <= misal_d & ~illegal_d & req_we_i;
                        end else begin
                            state_q <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (we_q) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= 32'h0000_0000;
                    end else if (cnt_q == RD_LAT_C) begin
                        // Read data has arrived from the RAM this cycle.
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= load_ext(op_q, addr_q[1:0], ram_word_d);
`ifdef DMEM_CTRL_PARITY_EN
                        perr_q       <= perr_d;
`endif
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                RESP: begin
                    if (resp_ready_i) begin
                        state_q      <= IDLE;
                        req_ready_q  <= 1'b1;
                        resp_valid_q <= 1'b0;
                        resp_rdata_q <= 32'h0000_0000;
                        adel_q       <= 1'b0;
                        ades_q       <= 1'b0;
                        busy_q       <= 1'b0;
`ifdef DMEM_CTRL_PARITY_EN
                        perr_q       <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    // Ready is forced low while rst is held, so it rises the cycle rst drops.
    assign req_ready_o  = req_ready_q & ~rst;
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_adel_o  = adel_q;
    assign resp_ades_o  = ades_q;
    assign busy_o       = busy_q;
`ifdef DMEM_CTRL_PARITY_EN
    assign resp_perr_o  = perr_q;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed plus random self-checking bench for dmem_ctrl.
// The reference model is a byte-addressed big-endian memory image.
module tb_dmem_ctrl;

    localparam int DEPTH_LOG2 = 14;
    localparam int RD_LAT     = 1;
    localparam int ADDR_W     = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_op;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_adel;
    logic        resp_ades;
    logic        busy;
`ifdef DMEM_CTRL_PARITY_EN
    logic        resp_perr;
`endif

    int errors = 0;
    int checks = 0;
    logic [7:0] mb [int];

    always #5 clk = ~clk;

    dmem_ctrl #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .RD_LAT     (RD_LAT),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .req_op_i     (req_op),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_rdata_o (resp_rdata),
        .resp_adel_o  (resp_adel),
        .resp_ades_o  (resp_ades),
        .busy_o       (busy)
`ifdef DMEM_CTRL_PARITY_EN
        ,
        .resp_perr_o  (resp_perr)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete transaction checked against the memory-image model.
    task automatic do_req(input logic we, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input int hold);
        bit          illegal, misal, got;
        int          sz, ba, lat, exp_lat;
        logic [31:0] exp_rd;
        illegal = (op == 3'b011) || (we && op[2]) || (!we && (op == 3'b001 || op == 3'b010));
        sz      = (op == 3'b000) ? 4 : ((op == 3'b001 || op == 3'b100 || op == 3'b101) ? 2 : 1);
        ba      = int'(addr[15:0]);
        misal   = !illegal && ((ba % sz) != 0);
        exp_lat = (illegal || misal) ? 1 : (we ? 2 : 2 + RD_LAT);
        exp_rd  = 32'h0;
        if (!illegal && !misal) begin
            if (we) begin
                for (int k = 0; k < sz; k++) mb[ba + k] = 8'(wd >> ((sz - 1 - k) * 8));
            end else begin
                for (int k = 0; k < sz; k++)
                    exp_rd = (exp_rd << 8) | 32'(mb.exists(ba + k) ? mb[ba + k] : 8'h00);
                if (op == 3'b110 && exp_rd >= 32'd128)    exp_rd = exp_rd | 32'hFFFF_FF00;
                if (op == 3'b100 && exp_rd >= 32'h8000)   exp_rd = exp_rd | 32'hFFFF_0000;
            end
        end

        @(negedge clk);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_op    = 3'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;

        got = 1'b0; lat = 0;
        for (int n = 1; n <= 20 && !got; n++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin got = 1'b1; lat = n; end
        end
        check("latency", 32'(lat), 32'(exp_lat));

        for (int h = 0; h <= hold; h++) begin
            if (h > 0) @(negedge clk);
            check("resp_valid", 32'(resp_valid), 32'd1);
            check("resp_rdata", resp_rdata, exp_rd);
            check("resp_adel", 32'(resp_adel), 32'(misal && !we));
            check("resp_ades", 32'(resp_ades), 32'(misal && we));
            check("req_ready_busy", 32'(req_ready), 32'd0);
            check("busy_inflight", 32'(busy), 32'd1);
`ifdef DMEM_CTRL_PARITY_EN
            check("resp_perr", 32'(resp_perr), 32'd0);
`endif
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_resp_valid", 32'(resp_valid), 32'd0);
        check("idle_req_ready", 32'(req_ready), 32'd1);
    endtask

    function automatic logic [2:0] pick_op(input logic we);
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 3'($urandom_range(0, 7));
        if (we) begin
            case ($urandom_range(0, 2))
                0:       return 3'b000;
                1:       return 3'b001;
                default: return 3'b010;
            endcase
        end
        case ($urandom_range(0, 4))
            0:       return 3'b000;
            1:       return 3'b100;
            2:       return 3'b101;
            3:       return 3'b110;
            default: return 3'b111;
        endcase
    endfunction

    initial begin
        logic        rwe;
        logic [31:0] raddr;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_op = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_adel", 32'(resp_adel), 32'd0);
        check("rst_ades", 32'(resp_ades), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 32'd1);

        // Known contents for every location the bench will read
        for (int a = 0; a < 32'h300; a += 4) do_req(1'b1, 3'b000, 32'(a), $urandom, 0);

        // Word, byte and half round trips
        do_req(1'b1, 3'b000, 32'h100, 32'h1122_3344, 0);
        do_req(1'b0, 3'b000, 32'h100, 32'h0, 0);
        do_req(1'b1, 3'b010, 32'h103, 32'h0000_00A5, 0);
        do_req(1'b0, 3'b000, 32'h100, 32'h0, 0);
        do_req(1'b0, 3'b110, 32'h103, 32'h0, 0);
        do_req(1'b0, 3'b111, 32'h103, 32'h0, 0);
        do_req(1'b1, 3'b001, 32'h102, 32'h0000_8001, 0);
        do_req(1'b0, 3'b100, 32'h102, 32'h0, 0);
        do_req(1'b0, 3'b101, 32'h100, 32'h0, 0);

        // Alignment faults leave memory unchanged
        do_req(1'b0, 3'b000, 32'h101, 32'h0, 0);
        do_req(1'b1, 3'b001, 32'h203, 32'hFFFF_FFFF, 0);
        do_req(1'b0, 3'b000, 32'h100, 32'h0, 0);
        do_req(1'b0, 3'b000, 32'h200, 32'h0, 0);

        // Illegal we/op pairings
        do_req(1'b0, 3'b001, 32'h100, 32'h0, 0);
        do_req(1'b1, 3'b110, 32'h100, 32'h55, 0);
        do_req(1'b1, 3'b011, 32'h100, 32'h55, 0);
        do_req(1'b0, 3'b000, 32'h100, 32'h0, 0);

        // Upper address bits alias
        do_req(1'b1, 3'b000, 32'hABCD_0108, 32'hCAFE_F00D, 0);
        do_req(1'b0, 3'b000, 32'h0000_0108, 32'h0, 0);

        // Response back-pressure
        do_req(1'b0, 3'b000, 32'h100, 32'h0, 5);

        // Reset during a store's ACCESS cycle drops the write
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_op = 3'b000; req_addr = 32'h104; req_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("store_rst_resp_valid", 32'(resp_valid), 32'd0);
        check("store_rst_ready", 32'(req_ready), 32'd1);
        check("store_rst_busy", 32'(busy), 32'd0);
        do_req(1'b0, 3'b000, 32'h104, 32'h0, 0);

        // Reset discards a pending load response
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_op = 3'b000; req_addr = 32'h100;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2 + RD_LAT) @(negedge clk);
        check("load_pending_valid", 32'(resp_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("load_rst_resp_valid", 32'(resp_valid), 32'd0);
        check("load_rst_ready", 32'(req_ready), 32'd1);

        // Random traffic
        for (int i = 0; i < 150; i++) begin
            rwe   = 1'($urandom_range(0, 1));
            raddr = {16'($urandom), 16'($urandom_range(0, 32'h2FF))};
            do_req(rwe, pick_op(rwe), raddr, $urandom, $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
